// File: rtl/tcs3200_rgb_capture.sv
// TCS3200 colour front end: cycles the R/B/G filters, counts sensor edges over a fixed gate
// and scales each count against a stored white reference into the 8-bit data_r/g/b bus.
module tcs3200_rgb_capture #(
    parameter int GATE_CYCLES   = 500000,
    parameter int SETTLE_CYCLES = 5000,
    parameter int CNT_W         = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       sensor_out,
    input  logic       cal_white,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic [7:0] data_r,
    output logic [7:0] data_g,
    output logic [7:0] data_b,
    output logic       data_valid,
    output logic       cal_done
);
    localparam int DW         = CNT_W + 8;
    localparam int DIV_CYCLES = DW + 1;
    localparam int TMR_MAX    = (GATE_CYCLES > SETTLE_CYCLES)
                              ? ((GATE_CYCLES > DIV_CYCLES) ? GATE_CYCLES : DIV_CYCLES)
                              : ((SETTLE_CYCLES > DIV_CYCLES) ? SETTLE_CYCLES : DIV_CYCLES);
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_GATE   = 2'd1;
    localparam logic [1:0] ST_DIV    = 2'd2;
    localparam logic [1:0] CH_R      = 2'd0;
    localparam logic [1:0] CH_B      = 2'd1;
    localparam logic [1:0] CH_G      = 2'd2;

    logic [1:0]       state_q, state_d, ch_q, ch_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, raw_r_q, raw_r_d, raw_b_q, raw_b_d;
    logic [CNT_W-1:0] white_r_q, white_r_d, white_g_q, white_g_d, white_b_q, white_b_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [7:0]       sh_r_q, sh_r_d, sh_b_q, sh_b_d;
    logic [7:0]       data_r_q, data_r_d, data_g_q, data_g_d, data_b_q, data_b_d;
    logic             data_valid_q, data_valid_d, cal_done_q, cal_done_d;
    logic             cal_pend_q, cal_pend_d, cal_frame_q, cal_frame_d;

    logic             rise, tmr_last, adv, ge;
    logic [CNT_W-1:0] cnt_inc, white_sel, rem_step;
    logic [CNT_W:0]   rem_sh;
    logic [DW-1:0]    quo_step, prod;
    logic [7:0]       res;

    always_comb begin
        rise    = sync_q[1] & ~prev_q;
        cnt_inc = (rise && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        prod    = {cnt_q, 8'b0} - {8'b0, cnt_q};

        case (ch_q)
            CH_R:    white_sel = white_r_q;
            CH_B:    white_sel = white_b_q;
            default: white_sel = white_g_q;
        endcase

        // Remainder stays below the divisor, so only its low CNT_W bits need storing.
        rem_sh   = {rem_q, quo_q[DW-1]};
        ge       = rem_sh[CNT_W] | (rem_sh[CNT_W-1:0] >= white_sel);
        rem_step = ge ? rem_sh[CNT_W-1:0] - white_sel : rem_sh[CNT_W-1:0];
        quo_step = {quo_q[DW-2:0], ge};

        if (white_sel == '0)
            res = (|cnt_q[CNT_W-1:8]) ? 8'hFF : cnt_q[7:0];
        else
            res = (|quo_step[DW-1:8]) ? 8'hFF : quo_step[7:0];

        case (state_q)
            ST_SETTLE: tmr_last = (tmr_q == TMR_W'(SETTLE_CYCLES - 1));
            ST_GATE:   tmr_last = (tmr_q == TMR_W'(GATE_CYCLES - 1));
            ST_DIV:    tmr_last = (tmr_q == TMR_W'(DIV_CYCLES - 1));
            default:   tmr_last = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        tmr_d        = tmr_q + TMR_W'(1);
        cnt_d        = cnt_q;
        raw_r_d      = raw_r_q;
        raw_b_d      = raw_b_q;
        white_r_d    = white_r_q;
        white_g_d    = white_g_q;
        white_b_d    = white_b_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        sh_r_d       = sh_r_q;
        sh_b_d       = sh_b_q;
        data_r_d     = data_r_q;
        data_g_d     = data_g_q;
        data_b_d     = data_b_q;
        data_valid_d = 1'b0;
        cal_done_d   = 1'b0;
        cal_pend_d   = cal_pend_q | cal_white;
        cal_frame_d  = cal_frame_q;
        adv          = 1'b0;

        case (state_q)
            ST_SETTLE: begin
                cnt_d = '0;
                if (tmr_last) begin
                    state_d = ST_GATE;
                    tmr_d   = '0;
                end
            end
            ST_GATE: begin
                cnt_d = cnt_inc;
                if (tmr_last) begin
                    tmr_d = '0;
                    if (cal_frame_q) begin
                        adv = 1'b1;
                        case (ch_q)
                            CH_R: raw_r_d = cnt_inc;
                            CH_B: raw_b_d = cnt_inc;
                            default: begin
                                white_r_d  = raw_r_q;
                                white_b_d  = raw_b_q;
                                white_g_d  = cnt_inc;
                                cal_done_d = 1'b1;
                            end
                        endcase
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                if (tmr_q == '0) begin
                    quo_d = prod;
                    rem_d = '0;
                end else if (white_sel != '0) begin
                    quo_d = quo_step;
                    rem_d = rem_step;
                end
                if (tmr_last) begin
                    tmr_d = '0;
                    adv   = 1'b1;
                    case (ch_q)
                        CH_R: sh_r_d = res;
                        CH_B: sh_b_d = res;
                        default: begin
                            data_r_d     = sh_r_q;
                            data_b_d     = sh_b_q;
                            data_g_d     = res;
                            data_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_SETTLE;
                tmr_d   = '0;
            end
        endcase

        if (adv) begin
            state_d = ST_SETTLE;
            if (ch_q == CH_G) begin
                ch_d        = CH_R;
                cal_frame_d = cal_pend_q;
                cal_pend_d  = cal_white;
            end else begin
                ch_d = ch_q + 2'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_SETTLE;
            ch_q         <= CH_R;
            tmr_q        <= '0;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            raw_r_q      <= '0;
            raw_b_q      <= '0;
            white_r_q    <= '0;
            white_g_q    <= '0;
            white_b_q    <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            sh_r_q       <= '0;
            sh_b_q       <= '0;
            data_r_q     <= '0;
            data_g_q     <= '0;
            data_b_q     <= '0;
            data_valid_q <= 1'b0;
            cal_done_q   <= 1'b0;
            cal_pend_q   <= 1'b0;
            cal_frame_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            tmr_q        <= tmr_d;
            sync_q       <= {sync_q[0], sensor_out};
            prev_q       <= sync_q[1];
            cnt_q        <= cnt_d;
            raw_r_q      <= raw_r_d;
            raw_b_q      <= raw_b_d;
            white_r_q    <= white_r_d;
            white_g_q    <= white_g_d;
            white_b_q    <= white_b_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            sh_r_q       <= sh_r_d;
            sh_b_q       <= sh_b_d;
            data_r_q     <= data_r_d;
            data_g_q     <= data_g_d;
            data_b_q     <= data_b_d;
            data_valid_q <= data_valid_d;
            cal_done_q   <= cal_done_d;
            cal_pend_q   <= cal_pend_d;
            cal_frame_q  <= cal_frame_d;
        end
    end

    assign s0         = 1'b1;
    assign s1         = 1'b0;
    assign s2         = (ch_q == CH_G);
    assign s3         = (ch_q != CH_R);
    assign data_r     = data_r_q;
    assign data_g     = data_g_q;
    assign data_b     = data_b_q;
    assign data_valid = data_valid_q;
    assign cal_done   = cal_done_q;

endmodule

// File: tb/tb_tcs3200_rgb_capture.sv
// Bench for tcs3200_rgb_capture: a square-wave sensor follows s2/s3 and a frame-level model
// predicts counts, scaling, calibration and frame timing.
module tb_tcs3200_rgb_capture;
    localparam int GATE     = 1000;
    localparam int SETTLE   = 10;
    localparam int LEN_NORM = 3 * (SETTLE + GATE + 29);
    localparam int LEN_CAL  = 3 * (SETTLE + GATE);

    logic       sys_clk    = 1'b0;
    logic       sys_rst    = 1'b1;
    logic       sensor_out = 1'b0;
    logic       cal_white  = 1'b0;
    logic       s0, s1, s2, s3;
    logic [7:0] data_r, data_g, data_b;
    logic       data_valid, cal_done;

    tcs3200_rgb_capture #(
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (20)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sensor_out (sensor_out),
        .cal_white  (cal_white),
        .s0         (s0),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3),
        .data_r     (data_r),
        .data_g     (data_g),
        .data_b     (data_b),
        .data_valid (data_valid),
        .cal_done   (cal_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fnum  = 0;

    // Channel index: 0 = R, 1 = B, 2 = G. smode: 0 square wave, 1 held low, 2 held high.
    int per[3] = '{20, 50, 100};
    int smode  = 0;
    int m_white[3] = '{0, 0, 0};
    int m_data[3]  = '{0, 0, 0};
    int m_cnt[3]   = '{0, 0, 0};
    bit m_pend     = 1'b0;
    bit m_cur_cal  = 1'b0;

    int s_ph = 0, s_lch = -1, s_lp = 0, s_ch = 0, s_p = 1;
    always @(negedge sys_clk) begin
        s_ch = (!s2 && !s3) ? 0 : (!s2 ? 1 : 2);
        s_p  = per[s_ch];
        if (s_ch != s_lch || s_p != s_lp) s_ph = 0;
        else                              s_ph = (s_ph + 1) % s_p;
        s_lch = s_ch;
        s_lp  = s_p;
        case (smode)
            1:       sensor_out = 1'b0;
            2:       sensor_out = 1'b1;
            default: sensor_out = (s_ph < s_p / 2);
        endcase
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string s);
        return $sformatf("f%0d_%s", fnum, s);
    endfunction

    function automatic int obs_data(input int c);
        if (c == 0) return int'(data_r);
        if (c == 1) return int'(data_b);
        return int'(data_g);
    endfunction

    task automatic set_frame(input int pr, input int pb, input int pg, input int mode);
        per[0] = pr;
        per[1] = pb;
        per[2] = pg;
        smode  = mode;
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = (mode != 0) ? 0 : GATE / per[c];
            if (m_cnt[c] > 1048575) m_cnt[c] = 1048575;
        end
    endtask

    task automatic wait_event(output bit dv, output bit cd, output int cyc);
        dv  = 1'b0;
        cd  = 1'b0;
        cyc = 0;
        while (cyc < 4000 && !(dv || cd)) begin
            @(negedge sys_clk);
            cyc++;
            dv = data_valid;
            cd = cal_done;
        end
    endtask

    task automatic pulse_cal(input int after);
        repeat (after - 1) @(negedge sys_clk);
        cal_white = 1'b1;
        @(negedge sys_clk);
        cal_white = 1'b0;
    endtask

    // Runs one frame from its first cycle to its end event; c1/c2 are cal pulse offsets (0 = none).
    task automatic do_frame(input int pr, input int pb, input int pg, input int mode,
                            input int c1, input int c2);
        bit dv, cd, pre, post;
        int cyc, len, e;
        set_frame(pr, pb, pg, mode);
        len = m_cur_cal ? LEN_CAL : LEN_NORM;
        fork
            wait_event(dv, cd, cyc);
            if (c1 > 0) pulse_cal(c1);
            if (c2 > 0) pulse_cal(c2);
        join
        fnum++;
        chk(tg("period"), cyc, len);
        chk(tg("excl"), dv & cd, 0);
        if (m_cur_cal) begin
            chk(tg("cal_done"), cd, 1);
            for (int c = 0; c < 3; c++) begin
                m_white[c] = m_cnt[c];
                chk(tg($sformatf("hold%0d", c)), obs_data(c), m_data[c]);
            end
        end else begin
            chk(tg("data_valid"), dv, 1);
            for (int c = 0; c < 3; c++) begin
                if (m_white[c] == 0) e = m_cnt[c];
                else                 e = (m_cnt[c] * 255) / m_white[c];
                if (e > 255) e = 255;
                m_data[c] = e;
                chk(tg($sformatf("data%0d", c)), obs_data(c), e);
            end
        end
        pre  = (c1 > 0 && c1 < len) || (c2 > 0 && c2 < len);
        post = (c1 >= len) || (c2 >= len);
        m_cur_cal = m_pend | pre;
        m_pend    = post;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int divs[14] = '{2, 4, 5, 8, 10, 20, 25, 40, 50, 100, 125, 200, 250, 500};
        int c1;
        set_frame(20, 50, 100, 0);
        repeat (4) @(negedge sys_clk);
        chk("rst_data_r", data_r, 0);
        chk("rst_data_g", data_g, 0);
        chk("rst_data_b", data_b, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_cal_done", cal_done, 0);
        chk("rst_s2", s2, 0);
        chk("rst_s3", s3, 0);
        chk("rst_s0", s0, 1);
        chk("rst_s1", s1, 0);
        sys_rst = 1'b0;

        // Uncalibrated counts, then calibration at 100 and scaled / saturated frames.
        do_frame(20, 50, 100, 0, 0, 0);
        do_frame(20, 50, 100, 0, 0, 0);
        do_frame(10, 10, 10, 0, 500, 0);
        do_frame(10, 10, 10, 0, 0, 0);
        do_frame(20, 40, 10, 0, 0, 0);
        do_frame(5, 10, 20, 0, 0, 0);

        // One-cycle reset during DIV(G) of a normal frame.
        set_frame(20, 50, 100, 0);
        repeat (3100) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("mid_rst_data_r", data_r, 0);
        chk("mid_rst_data_g", data_g, 0);
        chk("mid_rst_data_b", data_b, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_s2", s2, 0);
        chk("mid_rst_s3", s3, 0);
        m_white   = '{0, 0, 0};
        m_data    = '{0, 0, 0};
        m_pend    = 1'b0;
        m_cur_cal = 1'b0;
        do_frame(20, 50, 100, 0, 0, 0);

        // Stuck sensor: zero outputs, and a stuck calibration leaves channels uncalibrated.
        do_frame(10, 10, 10, 0, 300, 0);
        do_frame(10, 10, 10, 0, 0, 0);
        do_frame(10, 10, 10, 2, 200, 0);
        do_frame(10, 10, 10, 1, 0, 0);
        do_frame(20, 50, 100, 0, 0, 0);

        // Two requests inside GATE(B) collapse into one cal frame.
        do_frame(10, 10, 10, 0, 1300, 1600);
        do_frame(10, 10, 10, 0, 0, 0);
        do_frame(20, 40, 10, 0, 0, 0);

        // Request landing on the SETTLE(R) entry edge is deferred one frame.
        do_frame(20, 20, 20, 0, LEN_NORM, 0);
        do_frame(25, 50, 125, 0, 0, 0);
        do_frame(10, 20, 40, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            c1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(100, 2900)) : 0;
            do_frame(divs[$urandom_range(0, 13)], divs[$urandom_range(0, 13)],
                     divs[$urandom_range(0, 13)], 0, c1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
